// File: rtl/decode_stage_pkg.sv
// Shared decode constants: opcode encodings and ALU operation codes.
package decode_stage_pkg;

    localparam logic [6:0] OPC_NOP = 7'h00;
    localparam logic [6:0] OPC_MOV = 7'h01;
    localparam logic [6:0] OPC_LDI = 7'h04;
    localparam logic [6:0] OPC_ADD = 7'h07;
    localparam logic [6:0] OPC_ADI = 7'h08;
    localparam logic [6:0] OPC_ADC = 7'h09;
    localparam logic [6:0] OPC_SUB = 7'h0a;
    localparam logic [6:0] OPC_SUC = 7'h0b;
    localparam logic [6:0] OPC_CMP = 7'h0c;
    localparam logic [6:0] OPC_CMI = 7'h0d;
    localparam logic [6:0] OPC_JMP = 7'h0e;

    localparam int unsigned ALU_MODE_W = 2;

    typedef enum logic [ALU_MODE_W-1:0] {
        ALU_L_PASS = 2'd0,
        ALU_R_PASS = 2'd1,
        ALU_ADD    = 2'd2,
        ALU_SUB    = 2'd3
    } alu_mode_e;

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Combinational instruction-word decoder; also reports which operand selects are read.
// DECODE_ILLEGAL_EN adds illegal_o for undefined opcodes.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int unsigned REGNO     = 8,
    parameter int unsigned REGNO_LOG = 3
) (
    input  logic [15:0]           instr_i,
    output logic                  pc_inc_o,
    output logic                  pc_ie_o,
    output logic                  r_bus_imm_o,
    output logic                  carry_en_o,
    output logic                  flags_ie_o,
    output logic [ALU_MODE_W-1:0] alu_mode_o,
    output logic [REGNO_LOG-1:0]  l_sel_o,
    output logic [REGNO_LOG-1:0]  r_sel_o,
    output logic [REGNO-1:0]      rf_ie_o,
`ifdef DECODE_ILLEGAL_EN
    output logic                  illegal_o,
`endif
    output logic                  reads_l_o,
    output logic                  reads_r_o
);

    logic [REGNO_LOG-1:0] dst;
    logic [REGNO_LOG-1:0] st;
    logic [REGNO_LOG-1:0] nd;
    logic                 wr;
    alu_mode_e            mode;

    // 3-bit instruction fields are truncated or zero-extended to REGNO_LOG
    always_comb begin
        dst = '0;
        st  = '0;
        nd  = '0;
        for (int unsigned i = 0; i < REGNO_LOG && i < 3; i++) begin
            dst[i] = instr_i[7+i];
            st[i]  = instr_i[10+i];
            nd[i]  = instr_i[13+i];
        end
    end

    always_comb begin
        pc_inc_o    = 1'b1;
        pc_ie_o     = 1'b0;
        r_bus_imm_o = 1'b0;
        carry_en_o  = 1'b0;
        flags_ie_o  = 1'b0;
        mode        = ALU_L_PASS;
        reads_l_o   = 1'b0;
        reads_r_o   = 1'b0;
        wr          = 1'b0;
`ifdef DECODE_ILLEGAL_EN
        illegal_o   = 1'b0;
`endif
        case (instr_i[6:0])
            OPC_NOP: ;
            OPC_MOV: begin
                mode      = ALU_L_PASS;
                reads_l_o = 1'b1;
                wr        = 1'b1;
            end
            OPC_LDI: begin
                mode        = ALU_R_PASS;
                r_bus_imm_o = 1'b1;
                wr          = 1'b1;
            end
            OPC_ADD, OPC_ADC: begin
                mode       = ALU_ADD;
                reads_l_o  = 1'b1;
                reads_r_o  = 1'b1;
                wr         = 1'b1;
                flags_ie_o = 1'b1;
                carry_en_o = (instr_i[6:0] == OPC_ADC);
            end
            OPC_ADI: begin
                mode        = ALU_ADD;
                reads_l_o   = 1'b1;
                r_bus_imm_o = 1'b1;
                wr          = 1'b1;
                flags_ie_o  = 1'b1;
            end
            OPC_SUB, OPC_SUC: begin
                mode       = ALU_SUB;
                reads_l_o  = 1'b1;
                reads_r_o  = 1'b1;
                wr         = 1'b1;
                flags_ie_o = 1'b1;
                carry_en_o = (instr_i[6:0] == OPC_SUC);
            end
            OPC_CMP: begin
                mode       = ALU_SUB;
                reads_l_o  = 1'b1;
                reads_r_o  = 1'b1;
                flags_ie_o = 1'b1;
            end
            OPC_CMI: begin
                mode        = ALU_SUB;
                reads_l_o   = 1'b1;
                r_bus_imm_o = 1'b1;
                flags_ie_o  = 1'b1;
            end
            OPC_JMP: begin
                pc_inc_o    = 1'b0;
                pc_ie_o     = 1'b1;
                mode        = ALU_R_PASS;
                r_bus_imm_o = 1'b1;
            end
            default: begin
`ifdef DECODE_ILLEGAL_EN
                illegal_o = 1'b1;
`endif
            end
        endcase
    end

    assign alu_mode_o = mode;
    assign l_sel_o    = reads_l_o ? st : '0;
    assign r_sel_o    = reads_r_o ? nd : '0;
    assign rf_ie_o    = wr ? (REGNO'(1) << dst) : '0;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: skid entry + registered output bundle, RAW scoreboard, flush.
// Optional DECODE_ILLEGAL_EN adds the o_illegal output.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned REGNO     = 8,
    parameter int unsigned REGNO_LOG = 3,
    parameter int unsigned IMM_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [15:0]           i_instr_l,
    input  logic [IMM_W-1:0]      i_imm_pass,
    input  logic                  i_submit,
    output logic                  o_ready,
    output logic                  o_submit,
    input  logic                  i_next_ready,
    input  logic                  i_flush,
    input  logic                  i_wb_valid,
    input  logic [REGNO_LOG-1:0]  i_wb_reg,
    output logic [IMM_W-1:0]      o_imm_pass,
    output logic                  oc_pc_inc,
    output logic                  oc_pc_ie,
    output logic                  oc_r_bus_imm,
    output logic                  oc_alu_carry_en,
    output logic                  oc_alu_flags_ie,
    output logic [ALU_MODE_W-1:0] oc_alu_mode,
    output logic [REGNO_LOG-1:0]  oc_l_reg_sel,
    output logic [REGNO_LOG-1:0]  oc_r_reg_sel,
    output logic [REGNO-1:0]      oc_rf_ie
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                  o_illegal
`endif
);

    logic                  skid_valid_q, skid_valid_d;
    logic [15:0]           skid_instr_q;
    logic [IMM_W-1:0]      skid_imm_q;
    logic                  out_valid_q, out_valid_d;
    logic [REGNO-1:0]      pending_q, pending_d;

    logic                  pc_inc_q, pc_ie_q, r_bus_imm_q, carry_en_q, flags_ie_q;
    logic [ALU_MODE_W-1:0] alu_mode_q;
    logic [REGNO_LOG-1:0]  l_sel_q, r_sel_q;
    logic [REGNO-1:0]      rf_ie_q;
    logic [IMM_W-1:0]      imm_q;

    logic                  in_accept, out_accept, head_valid, head_move, hazard;
    logic [15:0]           head_instr;
    logic [IMM_W-1:0]      head_imm;
    logic [REGNO-1:0]      blocked, wb_mask;

    logic                  d_pc_inc, d_pc_ie, d_r_bus_imm, d_carry_en, d_flags_ie;
    logic [ALU_MODE_W-1:0] d_alu_mode;
    logic [REGNO_LOG-1:0]  d_l_sel, d_r_sel;
    logic [REGNO-1:0]      d_rf_ie;
    logic                  d_reads_l, d_reads_r;
`ifdef DECODE_ILLEGAL_EN
    logic                  d_illegal, illegal_q;
`endif

    decode_logic #(
        .REGNO     (REGNO),
        .REGNO_LOG (REGNO_LOG)
    ) u_decode (
        .instr_i     (head_instr),
        .pc_inc_o    (d_pc_inc),
        .pc_ie_o     (d_pc_ie),
        .r_bus_imm_o (d_r_bus_imm),
        .carry_en_o  (d_carry_en),
        .flags_ie_o  (d_flags_ie),
        .alu_mode_o  (d_alu_mode),
        .l_sel_o     (d_l_sel),
        .r_sel_o     (d_r_sel),
        .rf_ie_o     (d_rf_ie),
`ifdef DECODE_ILLEGAL_EN
        .illegal_o   (d_illegal),
`endif
        .reads_l_o   (d_reads_l),
        .reads_r_o   (d_reads_r)
    );

    always_comb begin
        in_accept  = i_submit & ~skid_valid_q & ~i_flush;
        out_accept = out_valid_q & i_next_ready;
        head_valid = skid_valid_q | in_accept;
        head_instr = skid_valid_q ? skid_instr_q : i_instr_l;
        head_imm   = skid_valid_q ? skid_imm_q : i_imm_pass;

        // Registered pending bits only; a bundle leaving this cycle is not yet pending
        blocked = pending_q | ((out_valid_q & ~i_next_ready) ? rf_ie_q : '0);
        hazard  = (d_reads_l & blocked[d_l_sel]) | (d_reads_r & blocked[d_r_sel])
                | (|(d_rf_ie & blocked));

        head_move    = head_valid & ~i_flush & (~out_valid_q | i_next_ready) & ~hazard;
        skid_valid_d = ~i_flush & head_valid & ~head_move;
        out_valid_d  = ~i_flush & (head_move | (out_valid_q & ~i_next_ready));

        wb_mask   = i_wb_valid ? (REGNO'(1) << i_wb_reg) : '0;
        pending_d = (pending_q & ~wb_mask) | (out_accept ? rf_ie_q : '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_imm_q   <= '0;
            out_valid_q  <= 1'b0;
            pending_q    <= '0;
            pc_inc_q     <= 1'b1;
            pc_ie_q      <= 1'b0;
            r_bus_imm_q  <= 1'b0;
            carry_en_q   <= 1'b0;
            flags_ie_q   <= 1'b0;
            alu_mode_q   <= '0;
            l_sel_q      <= '0;
            r_sel_q      <= '0;
            rf_ie_q      <= '0;
            imm_q        <= '0;
`ifdef DECODE_ILLEGAL_EN
            illegal_q    <= 1'b0;
`endif
        end else begin
            skid_valid_q <= skid_valid_d;
            out_valid_q  <= out_valid_d;
            pending_q    <= pending_d;
            if (in_accept && !head_move) begin
                skid_instr_q <= i_instr_l;
                skid_imm_q   <= i_imm_pass;
            end
            if (head_move) begin
                pc_inc_q    <= d_pc_inc;
                pc_ie_q     <= d_pc_ie;
                r_bus_imm_q <= d_r_bus_imm;
                carry_en_q  <= d_carry_en;
                flags_ie_q  <= d_flags_ie;
                alu_mode_q  <= d_alu_mode;
                l_sel_q     <= d_l_sel;
                r_sel_q     <= d_r_sel;
                rf_ie_q     <= d_rf_ie;
                imm_q       <= head_imm;
`ifdef DECODE_ILLEGAL_EN
                illegal_q   <= d_illegal;
`endif
            end
        end
    end

    assign o_ready         = ~skid_valid_q;
    assign o_submit        = out_valid_q;
    assign o_imm_pass      = imm_q;
    assign oc_pc_inc       = pc_inc_q;
    assign oc_pc_ie        = pc_ie_q;
    assign oc_r_bus_imm    = r_bus_imm_q;
    assign oc_alu_carry_en = carry_en_q;
    assign oc_alu_flags_ie = flags_ie_q;
    assign oc_alu_mode     = alu_mode_q;
    assign oc_l_reg_sel    = l_sel_q;
    assign oc_r_reg_sel    = r_sel_q;
    assign oc_rf_ie        = rf_ie_q;
`ifdef DECODE_ILLEGAL_EN
    assign o_illegal       = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed words, expected bundles queued at issue time.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        logic        ill;
        logic        pinc;
        logic        pie;
        logic        rimm;
        logic        cy;
        logic        fl;
        logic [1:0]  mode;
        logic [2:0]  l;
        logic [2:0]  r;
        logic [7:0]  rf;
        logic [15:0] imm;
    } bundle_t;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic        clk, rst_n;
    logic [15:0] i_instr_l, i_imm_pass, o_imm_pass;
    logic        i_submit, o_ready, o_submit, i_next_ready, i_flush, i_wb_valid;
    logic [2:0]  i_wb_reg, oc_l_reg_sel, oc_r_reg_sel;
    logic        oc_pc_inc, oc_pc_ie, oc_r_bus_imm, oc_alu_carry_en, oc_alu_flags_ie;
    logic [1:0]  oc_alu_mode;
    logic [7:0]  oc_rf_ie;
    logic        o_illegal;

    int      checks = 0;
    int      errors = 0;
    bundle_t exp_q[$];
    bundle_t act;

    decode_stage #(.REGNO(8), .REGNO_LOG(3), .IMM_W(16)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_instr_l       (i_instr_l),
        .i_imm_pass      (i_imm_pass),
        .i_submit        (i_submit),
        .o_ready         (o_ready),
        .o_submit        (o_submit),
        .i_next_ready    (i_next_ready),
        .i_flush         (i_flush),
        .i_wb_valid      (i_wb_valid),
        .i_wb_reg        (i_wb_reg),
        .o_imm_pass      (o_imm_pass),
        .oc_pc_inc       (oc_pc_inc),
        .oc_pc_ie        (oc_pc_ie),
        .oc_r_bus_imm    (oc_r_bus_imm),
        .oc_alu_carry_en (oc_alu_carry_en),
        .oc_alu_flags_ie (oc_alu_flags_ie),
        .oc_alu_mode     (oc_alu_mode),
        .oc_l_reg_sel    (oc_l_reg_sel),
        .oc_r_reg_sel    (oc_r_reg_sel),
`ifdef DECODE_ILLEGAL_EN
        .oc_rf_ie        (oc_rf_ie),
        .o_illegal       (o_illegal)
`else
        .oc_rf_ie        (oc_rf_ie)
`endif
    );

`ifndef DECODE_ILLEGAL_EN
    assign o_illegal = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc(input logic [6:0] op, input logic [2:0] d,
                                        input logic [2:0] s, input logic [2:0] n);
        return {n, s, d, op};
    endfunction

    function automatic bundle_t mk(input logic ill, input logic pinc, input logic pie,
                                   input logic rimm, input logic cy, input logic fl,
                                   input logic [1:0] mode, input logic [2:0] l,
                                   input logic [2:0] r, input logic [7:0] rf,
                                   input logic [15:0] imm);
        bundle_t b;
        b = {ill, pinc, pie, rimm, cy, fl, mode, l, r, rf, imm};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] im, input bundle_t e);
        i_submit   = 1'b1;
        i_instr_l  = w;
        i_imm_pass = im;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        i_submit = 1'b0;
    endtask

    task automatic wb(input logic [2:0] r);
        i_wb_valid = 1'b1;
        i_wb_reg   = r;
        tick();
        i_wb_valid = 1'b0;
    endtask

    // Entered one step after a posedge with the stalled word parked in the skid entry
    task automatic wb_release(input logic [2:0] r, input string name);
        i_wb_valid = 1'b1;
        i_wb_reg   = r;
        @(negedge clk);
        chk({name, "_wb_cycle"}, o_submit, 0);
        tick();
        i_wb_valid = 1'b0;
        @(negedge clk);
        chk({name, "_still_stalled"}, o_submit, 0);
        tick();
        @(negedge clk);
        chk({name, "_emitted"}, o_submit, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && !i_flush && o_submit) begin
            act = {o_illegal, oc_pc_inc, oc_pc_ie, oc_r_bus_imm, oc_alu_carry_en,
                   oc_alu_flags_ie, oc_alu_mode, oc_l_reg_sel, oc_r_reg_sel, oc_rf_ie, o_imm_pass};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bundle actual=%h required=none", act);
            end else begin
                if (act !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bundle actual=%h required=%h", act, exp_q[0]);
                end
                if (i_next_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b1;
        i_instr_l    = '0;
        i_imm_pass   = '0;
        i_submit     = 1'b0;
        i_next_ready = 1'b1;
        i_flush      = 1'b0;
        i_wb_valid   = 1'b0;
        i_wb_reg     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_submit", o_submit, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_pc_inc", oc_pc_inc, 1);
        chk("rst_rf_ie", oc_rf_ie, 0);
        chk("rst_mode", oc_alu_mode, 0);
        chk("rst_imm", o_imm_pass, 0);
        chk("rst_illegal", o_illegal, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back ADD/SUB/ADC; ADC transfer coincides with writeback of r7
        send(enc(OPC_ADD, 3'd1, 3'd2, 3'd3), 16'h1111, mk(0,1,0,0,0,1,ALU_ADD,3'd2,3'd3,8'h02,16'h1111));
        @(negedge clk); chk("latency_not_yet", o_submit, 0);
        tick();
        send(enc(OPC_SUB, 3'd4, 3'd5, 3'd6), 16'h2222, mk(0,1,0,0,0,1,ALU_SUB,3'd5,3'd6,8'h10,16'h2222));
        @(negedge clk); chk("b2b_0", o_submit, 1);
        tick();
        send(enc(OPC_ADC, 3'd7, 3'd2, 3'd3), 16'h3333, mk(0,1,0,0,1,1,ALU_ADD,3'd2,3'd3,8'h80,16'h3333));
        @(negedge clk); chk("b2b_1", o_submit, 1);
        tick();
        idle();
        i_wb_valid = 1'b1;
        i_wb_reg   = 3'd7;
        @(negedge clk); chk("b2b_2", o_submit, 1);
        tick();
        i_wb_reg = 3'd1;
        @(negedge clk); chk("drain", o_submit, 0);
        tick();
        i_wb_reg = 3'd4;
        tick();
        i_wb_valid = 1'b0;

        // r7 must still be pending (set beat clear); unused r sel reads 0
        send(enc(OPC_MOV, 3'd0, 3'd7, 3'd5), 16'h0000, mk(0,1,0,0,0,0,ALU_L_PASS,3'd7,3'd0,8'h01,16'h0000));
        tick();
        idle();
        @(negedge clk);
        chk("setwins_ready", o_ready, 0);
        chk("setwins_stall", o_submit, 0);
        tick();
        @(negedge clk); chk("setwins_stall2", o_submit, 0);
        tick();
        wb_release(3'd7, "setwins");
        tick();
        wb(3'd0);

        // LDI r2 then ADD r3,r2,r1 stalls until r2 written back
        send(enc(OPC_LDI, 3'd2, 3'd6, 3'd7), 16'h00ab, mk(0,1,0,1,0,0,ALU_R_PASS,3'd0,3'd0,8'h04,16'h00ab));
        tick();
        idle();
        repeat (3) tick();
        send(enc(OPC_ADD, 3'd3, 3'd2, 3'd1), 16'h0000, mk(0,1,0,0,0,1,ALU_ADD,3'd2,3'd1,8'h08,16'h0000));
        tick();
        idle();
        @(negedge clk); chk("raw_ready", o_ready, 0);
        tick();
        wb_release(3'd2, "raw");
        tick();
        wb(3'd3);

        // Backpressure for 3 cycles with 2 words
        i_next_ready = 1'b0;
        send(enc(OPC_CMP, 3'd5, 3'd1, 3'd2), 16'h0c0c, mk(0,1,0,0,0,1,ALU_SUB,3'd1,3'd2,8'h00,16'h0c0c));
        tick();
        send(enc(OPC_JMP, 3'd3, 3'd4, 3'd5), 16'h0040, mk(0,0,1,1,0,0,ALU_R_PASS,3'd0,3'd0,8'h00,16'h0040));
        @(negedge clk); chk("bp_ready_first", o_ready, 1);
        tick();
        idle();
        @(negedge clk);
        chk("bp_ready_full", o_ready, 0);
        chk("bp_held", o_submit, 1);
        tick();
        i_next_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_ready_back", o_ready, 1);
        chk("bp_second", o_submit, 1);
        tick();
        tick();

        // Flush with skid and output full; r6 pending must survive
        send(enc(OPC_LDI, 3'd6, 3'd0, 3'd0), 16'h1234, mk(0,1,0,1,0,0,ALU_R_PASS,3'd0,3'd0,8'h40,16'h1234));
        tick();
        idle();
        tick();
        i_next_ready = 1'b0;
        send(enc(OPC_MOV, 3'd1, 3'd2, 3'd0), 16'h0000, mk(0,1,0,0,0,0,ALU_L_PASS,3'd2,3'd0,8'h02,16'h0000));
        tick();
        send(enc(OPC_ADI, 3'd4, 3'd5, 3'd0), 16'h0099, mk(0,1,0,1,0,1,ALU_ADD,3'd5,3'd0,8'h10,16'h0099));
        tick();
        idle();
        @(negedge clk);
        chk("flush_pre_ready", o_ready, 0);
        chk("flush_pre_submit", o_submit, 1);
        tick();
        i_flush    = 1'b1;
        i_submit   = 1'b1;
        i_instr_l  = enc(OPC_LDI, 3'd1, 3'd0, 3'd0);
        i_imm_pass = 16'hdead;
        exp_q.delete();
        tick();
        i_flush  = 1'b0;
        i_submit = 1'b0;
        @(negedge clk);
        chk("flush_submit", o_submit, 0);
        chk("flush_ready", o_ready, 1);
        tick();
        @(negedge clk); chk("flush_ignored_input", o_submit, 0);
        tick();
        i_next_ready = 1'b1;
        send(enc(OPC_MOV, 3'd1, 3'd6, 3'd0), 16'h0000, mk(0,1,0,0,0,0,ALU_L_PASS,3'd6,3'd0,8'h02,16'h0000));
        tick();
        idle();
        @(negedge clk); chk("flush_sb_kept", o_ready, 0);
        tick();
        wb_release(3'd6, "flush");
        tick();
        wb(3'd1);

        // Undefined opcode, NOP and CMI
        send(enc(7'h7f, 3'd3, 3'd4, 3'd5), 16'h7777, mk(ILL_EXP,1,0,0,0,0,ALU_L_PASS,3'd0,3'd0,8'h00,16'h7777));
        tick();
        send(enc(OPC_NOP, 3'd2, 3'd3, 3'd4), 16'h00f0, mk(0,1,0,0,0,0,ALU_L_PASS,3'd0,3'd0,8'h00,16'h00f0));
        tick();
        send(enc(OPC_CMI, 3'd6, 3'd3, 3'd4), 16'h0055, mk(0,1,0,1,0,1,ALU_SUB,3'd3,3'd0,8'h00,16'h0055));
        tick();
        idle();
        repeat (3) tick();

        // Async reset mid-stall clears everything including the scoreboard
        send(enc(OPC_LDI, 3'd5, 3'd0, 3'd0), 16'h0005, mk(0,1,0,1,0,0,ALU_R_PASS,3'd0,3'd0,8'h20,16'h0005));
        tick();
        idle();
        tick();
        tick();
        i_next_ready = 1'b0;
        send(enc(OPC_CMI, 3'd0, 3'd1, 3'd0), 16'h0011, mk(0,1,0,1,0,1,ALU_SUB,3'd1,3'd0,8'h00,16'h0011));
        tick();
        send(enc(OPC_ADD, 3'd2, 3'd5, 3'd0), 16'h0000, mk(0,1,0,0,0,1,ALU_ADD,3'd5,3'd0,8'h04,16'h0000));
        tick();
        idle();
        @(negedge clk);
        chk("prerst_ready", o_ready, 0);
        chk("prerst_submit", o_submit, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_submit", o_submit, 0);
        chk("arst_ready", o_ready, 1);
        chk("arst_pc_inc", oc_pc_inc, 1);
        chk("arst_rf_ie", oc_rf_ie, 0);
        chk("arst_imm", o_imm_pass, 0);
        chk("arst_lsel", oc_l_reg_sel, 0);
        tick();
        rst_n        = 1'b1;
        i_next_ready = 1'b1;
        send(enc(OPC_ADD, 3'd2, 3'd5, 3'd0), 16'h0000, mk(0,1,0,0,0,1,ALU_ADD,3'd5,3'd0,8'h04,16'h0000));
        @(negedge clk); chk("postrst_latency", o_submit, 0);
        tick();
        idle();
        @(negedge clk); chk("postrst_sb_cleared", o_submit, 1);
        tick();
        tick();

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
